// File: rtl/eth_pkg.sv
// Shared Ethernet/IP/UDP constants, TX state encoding and header capture payload.
package eth_pkg;

    localparam int unsigned PREAMBLE_LEN     = 8;
    localparam int unsigned ETH_HEAD_LEN     = 14;
    localparam int unsigned IP_HEAD_LEN      = 20;
    localparam int unsigned UDP_HEAD_LEN     = 8;
    localparam int unsigned CRC_LEN          = 4;
    localparam int unsigned CHECK_SUM_CYCLES = 4;
    localparam int unsigned MIN_PAYLOAD_LEN  = 18;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_TOS        = 8'h00;
    localparam logic [15:0] IP_FLAGS_FRAG = 16'h4000;
    localparam logic [7:0]  IP_TTL        = 8'h40;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

    typedef enum logic [7:0] {
        ST_IDLE      = 8'b0000_0001,
        ST_CHECK_SUM = 8'b0000_0010,
        ST_PREAMBLE  = 8'b0000_0100,
        ST_ETH_HEAD  = 8'b0000_1000,
        ST_IP_HEAD   = 8'b0001_0000,
        ST_UDP_HEAD  = 8'b0010_0000,
        ST_TX_DATA   = 8'b0100_0000,
        ST_CRC       = 8'b1000_0000
    } tx_state_e;

    typedef struct packed {
        logic [15:0] byte_num;
        logic [47:0] des_mac;
        logic [31:0] des_ip;
    } tx_hdr_t;

    function automatic logic [31:0] bitrev32(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// CRC-32 (poly 04C11DB7), one byte per cycle, bytes consumed LSB first as on the wire.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        en,
    input  logic        clr,
    output logic [31:0] crc
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;

    // Serial MSB-first register update unrolled over the 8 data bits.
    always_comb begin
        w_crc_nxt = r_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc_nxt[31] ^ data[i]) begin
                w_crc_nxt = {w_crc_nxt[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                w_crc_nxt = {w_crc_nxt[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= '1;
        end else if (clr) begin
            r_crc <= '1;
        end else if (en) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/udp_tx.sv
// GMII UDP/IPv4 frame transmitter: preamble, Ethernet/IP/UDP headers, payload, FCS.
// Optional `UDP_TX_PAD_EN pads short payloads with zeros to a 64-byte frame.
module udp_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [15:0] UDP_PORT  = 16'd1234
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start_en,
    input  logic [15:0] tx_byte_num,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    input  logic [31:0] tx_data,
    output logic        tx_req,
    output logic        tx_done,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);

    tx_state_e   r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    tx_hdr_t     r_hdr;
    logic [15:0] r_data_len, r_ip_len, r_udp_len, r_ident, r_chk;
    logic [31:0] r_sum, r_word;
    logic        r_tx_req, r_tx_done, r_tx_en;
    logic [7:0]  r_txd;
    logic        w_req_nxt, w_done_nxt, w_en_nxt;
    logic [7:0]  w_byte;
    logic [15:0] w_data_len;
    logic [31:0] w_sum0, w_crc, w_fcs, w_fcs_sh;
    logic        w_crc_en, w_crc_clr;
    logic [111:0] w_eth_vec, w_eth_sh;
    logic [159:0] w_ip_vec, w_ip_sh;
    logic [63:0]  w_udp_vec, w_udp_sh;

`ifdef UDP_TX_PAD_EN
    assign w_data_len = (tx_byte_num < 16'(MIN_PAYLOAD_LEN)) ? 16'(MIN_PAYLOAD_LEN) : tx_byte_num;
`else
    assign w_data_len = tx_byte_num;
`endif

    // Header images, MSB-first; the current byte is shifted into the top lane.
    assign w_eth_vec = {r_hdr.des_mac, BOARD_MAC, ETH_TYPE_IP};
    assign w_ip_vec  = {IP_VER_IHL, IP_TOS, r_ip_len, r_ident, IP_FLAGS_FRAG,
                        IP_TTL, IP_PROTO_UDP, r_chk, BOARD_IP, r_hdr.des_ip};
    assign w_udp_vec = {UDP_PORT, UDP_PORT, r_udp_len, 16'h0000};
    assign w_eth_sh  = w_eth_vec << {r_cnt[3:0], 3'b000};
    assign w_ip_sh   = w_ip_vec  << {r_cnt[4:0], 3'b000};
    assign w_udp_sh  = w_udp_vec << {r_cnt[2:0], 3'b000};
    assign w_fcs     = ~bitrev32(w_crc);
    assign w_fcs_sh  = w_fcs >> {r_cnt[1:0], 3'b000};

    assign w_sum0 = 32'(IP_VER_IHL) * 32'd256 + 32'(IP_TOS) + 32'(r_ip_len) + 32'(r_ident)
                  + 32'(IP_FLAGS_FRAG) + 32'({IP_TTL, IP_PROTO_UDP})
                  + 32'(BOARD_IP[31:16]) + 32'(BOARD_IP[15:0])
                  + 32'(r_hdr.des_ip[31:16]) + 32'(r_hdr.des_ip[15:0]);

    // Byte to be launched next cycle; the first byte of each word comes straight off tx_data.
    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            ST_PREAMBLE: w_byte = (r_cnt == 16'(PREAMBLE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
            ST_ETH_HEAD: w_byte = w_eth_sh[111:104];
            ST_IP_HEAD:  w_byte = w_ip_sh[159:152];
            ST_UDP_HEAD: w_byte = w_udp_sh[63:56];
            ST_TX_DATA: begin
                if (r_cnt < r_hdr.byte_num) begin
                    case (r_cnt[1:0])
                        2'd0:    w_byte = tx_data[31:24];
                        2'd1:    w_byte = r_word[23:16];
                        2'd2:    w_byte = r_word[15:8];
                        default: w_byte = r_word[7:0];
                    endcase
                end
            end
            ST_CRC:      w_byte = w_fcs_sh[7:0];
            default:     w_byte = 8'h00;
        endcase
    end

    assign w_crc_en  = (r_state == ST_ETH_HEAD) || (r_state == ST_IP_HEAD) ||
                       (r_state == ST_UDP_HEAD) || (r_state == ST_TX_DATA);
    assign w_crc_clr = (r_state == ST_IDLE);

    crc32_d8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (w_byte),
        .en    (w_crc_en),
        .clr   (w_crc_clr),
        .crc   (w_crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and next output values; tx_req leads the word's first wire byte by 2 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_req_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_en_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (tx_start_en) begin
                    w_state_nxt = ST_CHECK_SUM;
                end
            end
            ST_CHECK_SUM: begin
                if (r_cnt == 16'(CHECK_SUM_CYCLES - 1)) begin
                    w_state_nxt = ST_PREAMBLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PREAMBLE: begin
                w_en_nxt = 1'b1;
                if (r_cnt == 16'(PREAMBLE_LEN - 1)) begin
                    w_state_nxt = ST_ETH_HEAD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ETH_HEAD: begin
                w_en_nxt = 1'b1;
                if (r_cnt == 16'(ETH_HEAD_LEN - 1)) begin
                    w_state_nxt = ST_IP_HEAD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IP_HEAD: begin
                w_en_nxt = 1'b1;
                if (r_cnt == 16'(IP_HEAD_LEN - 1)) begin
                    w_state_nxt = ST_UDP_HEAD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_UDP_HEAD: begin
                w_en_nxt = 1'b1;
                if (r_cnt == 16'(UDP_HEAD_LEN - 2) && r_hdr.byte_num != 16'd0) begin
                    w_req_nxt = 1'b1;
                end
                if (r_cnt == 16'(UDP_HEAD_LEN - 1)) begin
                    w_state_nxt = (r_data_len != 16'd0) ? ST_TX_DATA : ST_CRC;
                    w_cnt_nxt   = '0;
                end
            end
            ST_TX_DATA: begin
                w_en_nxt = 1'b1;
                if (r_cnt[1:0] == 2'd2 && (r_cnt + 16'd2) < r_hdr.byte_num) begin
                    w_req_nxt = 1'b1;
                end
                if (r_cnt == r_data_len - 16'd1) begin
                    w_state_nxt = ST_CRC;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CRC: begin
                if (r_cnt == 16'(CRC_LEN)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_en_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_req  <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_en   <= 1'b0;
            r_txd     <= 8'h00;
        end else begin
            r_tx_req  <= w_req_nxt;
            r_tx_done <= w_done_nxt;
            r_tx_en   <= w_en_nxt;
            r_txd     <= w_en_nxt ? w_byte : 8'h00;
        end
    end

    // Capture, checksum pipeline (sum, fold, fold, invert), payload word and packet id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr      <= '0;
            r_data_len <= '0;
            r_ip_len   <= '0;
            r_udp_len  <= '0;
            r_ident    <= '0;
            r_chk      <= '0;
            r_sum      <= '0;
            r_word     <= '0;
        end else begin
            if (r_state == ST_IDLE && tx_start_en) begin
                r_hdr      <= '{byte_num: tx_byte_num, des_mac: des_mac, des_ip: des_ip};
                r_data_len <= w_data_len;
                r_ip_len   <= tx_byte_num + 16'(IP_HEAD_LEN + UDP_HEAD_LEN);
                r_udp_len  <= tx_byte_num + 16'(UDP_HEAD_LEN);
            end
            if (r_state == ST_CHECK_SUM) begin
                case (r_cnt[1:0])
                    2'd0:    r_sum <= w_sum0;
                    2'd1:    r_sum <= 32'(r_sum[31:16]) + 32'(r_sum[15:0]);
                    2'd2:    r_sum <= 32'(r_sum[31:16]) + 32'(r_sum[15:0]);
                    default: r_chk <= ~r_sum[15:0];
                endcase
            end
            if (r_state == ST_TX_DATA && r_cnt[1:0] == 2'd0) begin
                r_word <= tx_data;
            end
            if (w_done_nxt) begin
                r_ident <= r_ident + 16'd1;
            end
        end
    end

    assign tx_req     = r_tx_req;
    assign tx_done    = r_tx_done;
    assign gmii_tx_en = r_tx_en;
    assign gmii_txd   = r_txd;

endmodule

// File: tb/tb_udp_tx.sv
// Scoreboard bench for udp_tx: a byte-level frame model feeds a queue drained by a GMII monitor.
module tb_udp_tx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [15:0] UDP_PORT  = 16'd1234;
`ifdef UDP_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk, rst_n, tx_start_en, tx_req, tx_done, gmii_tx_en;
    logic [15:0] tx_byte_num;
    logic [47:0] des_mac;
    logic [31:0] des_ip, tx_data;
    logic [7:0]  gmii_txd;

    udp_tx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP), .UDP_PORT(UDP_PORT)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
        .des_mac(des_mac), .des_ip(des_ip), .tx_data(tx_data), .tx_req(tx_req),
        .tx_done(tx_done), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd)
    );

    typedef struct {
        int len;
        int nreq;
        int nbytes;
    } pkt_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    pkt_t        pkt_q[$];
    logic [31:0] word_q[$];
    logic [7:0]  cap[$];
    logic [7:0]  last_cap[$];
    int          done_cnt = 0;
    int          mon_pos = 0;
    int          req_n = 0;
    int          last_req_n = 0;
    int          cyc = 0;
    int          last_req_cyc = -100;
    bit          prev_en = 1'b0;
    logic [15:0] exp_ident = 16'd0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference frame built directly from the protocol field layout and a software CRC.
    task automatic build_frame(input int len, input logic [47:0] mac, input logic [31:0] ip,
                               input logic [15:0] ident, input logic [31:0] wq[$]);
        logic [7:0]  f[$];
        logic [7:0]  ih[20];
        logic [15:0] t;
        logic [31:0] sum, c, w;
        int          dlen, nw;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) f.push_back(mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(BOARD_MAC[8*i +: 8]);
        f.push_back(8'h08);
        f.push_back(8'h00);
        ih[0] = 8'h45; ih[1] = 8'h00;
        t = 16'(len + 28); ih[2] = t[15:8]; ih[3] = t[7:0];
        ih[4] = ident[15:8]; ih[5] = ident[7:0];
        ih[6] = 8'h40; ih[7] = 8'h00; ih[8] = 8'h40; ih[9] = 8'h11;
        ih[10] = 8'h00; ih[11] = 8'h00;
        for (int i = 0; i < 4; i++) ih[12+i] = BOARD_IP[31-8*i -: 8];
        for (int i = 0; i < 4; i++) ih[16+i] = ip[31-8*i -: 8];
        sum = 0;
        for (int i = 0; i < 20; i += 2) sum += {16'h0, ih[i], ih[i+1]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        t = ~sum[15:0];
        ih[10] = t[15:8]; ih[11] = t[7:0];
        for (int i = 0; i < 20; i++) f.push_back(ih[i]);
        f.push_back(UDP_PORT[15:8]); f.push_back(UDP_PORT[7:0]);
        f.push_back(UDP_PORT[15:8]); f.push_back(UDP_PORT[7:0]);
        t = 16'(len + 8); f.push_back(t[15:8]); f.push_back(t[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int j = 0; j < len; j++) begin
            w = wq[j/4];
            f.push_back(w[31-8*(j%4) -: 8]);
        end
        dlen = (PAD && len < 18) ? 18 : len;
        for (int j = len; j < dlen; j++) f.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < f.size(); i++) begin
            c = c ^ {24'h0, f[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        f.push_back(c[7:0]); f.push_back(c[15:8]); f.push_back(c[23:16]); f.push_back(c[31:24]);
        nw = (len + 3) / 4;
        foreach (f[i]) exp_q.push_back(f[i]);
        pkt_q.push_back('{len: len, nreq: nw, nbytes: f.size()});
    endtask

    task automatic start_pkt(input int len, input logic [47:0] mac, input logic [31:0] ip,
                             input logic [31:0] given[$]);
        logic [31:0] wq[$];
        for (int k = 0; k < (len + 3) / 4; k++) begin
            wq.push_back((k < given.size()) ? given[k] : $urandom);
            word_q.push_back(wq[k]);
        end
        build_frame(len, mac, ip, exp_ident, wq);
        exp_ident++;
        @(posedge clk); #1;
        tx_start_en = 1'b1;
        tx_byte_num = 16'(len);
        des_mac     = mac;
        des_ip      = ip;
        @(posedge clk); #1;
        tx_start_en = 1'b0;
        tx_byte_num = 16'($urandom);
        des_mac     = {$urandom, $urandom};
        des_ip      = $urandom;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 4000) begin
            @(posedge clk);
            t++;
        end
        chk(done_cnt >= target, "done_timeout", done_cnt, target);
        @(posedge clk);
    endtask

    task automatic flush_model();
        exp_q.delete();
        pkt_q.delete();
        word_q.delete();
        exp_ident = 16'd0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        flush_model();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] cap16(input int idx);
        return {last_cap[idx], last_cap[idx+1]};
    endfunction

    // Payload source: answers each tx_req with a word one cycle later, garbage otherwise.
    initial begin
        tx_data = 32'h0;
        forever begin
            @(posedge clk);
            if (rst_n && tx_req) begin
                #1;
                if (word_q.size() == 0) chk(1'b0, "src_unexpected_req", 1, 0);
                else tx_data = word_q.pop_front();
                @(posedge clk); #1;
                tx_data = $urandom;
            end
        end
    end

    // GMII monitor: compares every wire byte with the scoreboard and closes packets on tx_done.
    initial begin
        logic [7:0] e;
        int j;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_pos = 0;
                req_n   = 0;
                prev_en = 1'b0;
                cap.delete();
            end else begin
                cyc++;
                if (tx_req) begin
                    req_n++;
                    last_req_cyc = cyc;
                end
                if (gmii_tx_en) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_byte", gmii_txd, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(gmii_txd == e, $sformatf("byte[%0d]", mon_pos), gmii_txd, e);
                    end
                    if (pkt_q.size() > 0 && mon_pos >= 50) begin
                        j = mon_pos - 50;
                        if (j < pkt_q[0].len && j % 4 == 0)
                            chk(last_req_cyc == cyc - 2, "req_lead", cyc - last_req_cyc, 2);
                    end
                    cap.push_back(gmii_txd);
                    mon_pos++;
                end
                if (tx_done) begin
                    chk(prev_en && !gmii_tx_en, "done_edge", {prev_en, gmii_tx_en}, 2'b10);
                    if (pkt_q.size() == 0) begin
                        chk(1'b0, "unexpected_done", 1, 0);
                    end else begin
                        chk(req_n == pkt_q[0].nreq, "req_count", req_n, pkt_q[0].nreq);
                        chk(mon_pos == pkt_q[0].nbytes, "frame_len", mon_pos, pkt_q[0].nbytes);
                        void'(pkt_q.pop_front());
                    end
                    last_req_n = req_n;
                    last_cap   = cap;
                    cap.delete();
                    mon_pos = 0;
                    req_n   = 0;
                    done_cnt++;
                end
                prev_en = gmii_tx_en;
            end
        end
    end

    initial begin
        logic [31:0] none[$];
        logic [31:0] w8[$];
        logic [31:0] s;
        int d0, t;
        rst_n = 1'b0; tx_start_en = 1'b0; tx_byte_num = '0; des_mac = '0; des_ip = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(tx_req == 1'b0, "rst_tx_req", tx_req, 0);
        chk(tx_done == 1'b0, "rst_tx_done", tx_done, 0);
        chk(gmii_tx_en == 1'b0, "rst_tx_en", gmii_tx_en, 0);
        chk(gmii_txd == 8'h00, "rst_txd", gmii_txd, 0);
        @(negedge clk); rst_n = 1'b1;

        // 8-byte reference packet to broadcast MAC
        w8.push_back(32'h0102_0304);
        w8.push_back(32'h0506_0708);
        d0 = done_cnt;
        start_pkt(8, 48'hFFFF_FFFF_FFFF, {8'd192, 8'd168, 8'd1, 8'd102}, w8);
        wait_done(d0 + 1);
        chk(last_cap.size() == (PAD ? 72 : 62), "p8_size", last_cap.size(), PAD ? 72 : 62);
        chk(cap16(24) == 16'd36, "p8_ip_len", cap16(24), 36);
        chk(cap16(46) == 16'd16, "p8_udp_len", cap16(46), 16);
        chk(cap16(26) == 16'd0, "p8_ident", cap16(26), 0);
        s = 0;
        for (int i = 22; i < 42; i += 2) s += {16'h0, cap16(i)};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        chk(s == 32'hFFFF, "p8_ip_csum", s, 32'hFFFF);

        // 5-byte packet: partial final word
        d0 = done_cnt;
        start_pkt(5, {$urandom, $urandom}, $urandom, none);
        wait_done(d0 + 1);
        chk(last_req_n == 2, "p5_reqs", last_req_n, 2);
        chk(cap16(46) == 16'd13, "p5_udp_len", cap16(46), 13);

        // Empty payload
        d0 = done_cnt;
        start_pkt(0, {$urandom, $urandom}, $urandom, none);
        wait_done(d0 + 1);
        chk(last_req_n == 0, "p0_reqs", last_req_n, 0);
        chk(last_cap.size() == (PAD ? 72 : 54), "p0_size", last_cap.size(), PAD ? 72 : 54);

        // Back-to-back after reset, with a start pulse injected mid-frame
        do_reset();
        d0 = done_cnt;
        for (int p = 0; p < 3; p++) begin
            start_pkt($urandom_range(1, 40), {$urandom, $urandom}, $urandom, none);
            if (p == 1) begin
                repeat (20) @(posedge clk);
                #1;
                tx_start_en = 1'b1;
                tx_byte_num = 16'($urandom_range(1, 40));
                @(posedge clk); #1;
                tx_start_en = 1'b0;
            end
            wait_done(d0 + p + 1);
            chk(cap16(26) == 16'(p), "b2b_ident", cap16(26), p);
        end
        repeat (100) @(posedge clk);
        chk(done_cnt == d0 + 3, "b2b_done_count", done_cnt - d0, 3);

        // Reset while payload byte 10 is on the wire
        d0 = done_cnt;
        start_pkt(40, {$urandom, $urandom}, $urandom, none);
        t = 0;
        while (mon_pos < 61 && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        chk(mon_pos == 61, "abort_reach", mon_pos, 61);
        rst_n = 1'b0;
        #1;
        chk(gmii_tx_en == 1'b0, "abort_tx_en", gmii_tx_en, 0);
        chk(tx_done == 1'b0, "abort_tx_done", tx_done, 0);
        flush_model();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk(done_cnt == d0, "abort_no_done", done_cnt, d0);
        chk(gmii_tx_en == 1'b0, "abort_idle", gmii_tx_en, 0);

        start_pkt(12, {$urandom, $urandom}, $urandom, none);
        wait_done(d0 + 1);
        chk(cap16(26) == 16'd0, "post_abort_ident", cap16(26), 0);

        // Random traffic
        for (int p = 0; p < 6; p++) begin
            d0 = done_cnt;
            start_pkt($urandom_range(0, 70), {$urandom, $urandom}, $urandom, none);
            wait_done(d0 + 1);
        end
        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
